universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised universal shift register with a command handshake, the next generation of the team's bidirectional serial shift register. One accepted command loads the register in parallel or shifts/rotates it by a programmable number of positions, one position per enabled cycle, then pulses `done`. It sits between serial links and parallel datapaths: serialisers, deserialisers, barrel-free multi-bit shifting and bit-stream alignment.

## Interface
- `WIDTH`, 16: register width in bits, ≥2.
- `CNT_W`, `$clog2(WIDTH+1)`: width of the shift-count field.

- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `en`, in, 1: step enable. Low freezes an in-progress command.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: block idle, able to accept a command.
- `cmd_mode`, in, 3: 0 LOAD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 ASR, 6–7 illegal.
- `cmd_count`, in, CNT_W: positions to shift.
- `par_in`, in, WIDTH: parallel load data.
- `sin_lsb`, in, 1: bit entering bit 0 on SHL.
- `sin_msb`, in, 1: bit entering bit WIDTH-1 on SHR.
- `data_out`, out, WIDTH: register contents.
- `sout`, out, 1: bit shifted or rotated out on the most recent step.
- `done`, out, 1: one-cycle pulse when a command completes.
- `err`, out, 1: one-cycle pulse when an illegal command completes.

## Operation
- States: IDLE, RUN. `cmd_ready` = (state == IDLE).
- Accept occurs on an edge with `cmd_valid && cmd_ready`. `cmd_mode` and `cmd_count` are captured. `en` does not gate acceptance.
- LOAD: `data_out <= par_in` at the accept edge. `cmd_count` is ignored. The block stays in IDLE, and `done` is high the next cycle.
- Shift modes with count 0: no change. The block stays in IDLE, and `done` is high the next cycle.
- Illegal mode: no change to `data_out`. The block stays in IDLE, and both `done` and `err` are high the next cycle.
- Shift modes with count N>0: go to RUN with `rem = N`. Each RUN edge with `en=1` performs one step and decrements `rem`. The step that takes `rem` from 1 to 0 returns the block to IDLE and registers `done`.
- Step definitions:
  - SHL: `{d[W-2:0], sin_lsb}`, `sout = d[W-1]`.
  - SHR: `{sin_msb, d[W-1:1]}`, `sout = d[0]`.
  - ROL: `{d[W-2:0], d[W-1]}`, `sout = d[W-1]`.
  - ROR: `{d[0], d[W-1:1]}`, `sout = d[0]`.
  - ASR: `{d[W-1], d[W-1:1]}`, `sout = d[0]`.
- Serial inputs are sampled on every step, so they may change per cycle.
- Counts larger than WIDTH are legal and are not clamped. SHL/SHR fill the register entirely with serial input. Rotates wrap modulo WIDTH, in time only; each position still takes one step.
- `sout` is registered and holds its value between steps.
- `cmd_valid` while busy is ignored; it is not queued.

## Timing
- Reset values: `data_out=0`, `sout=0`, `done=0`, `err=0`, `cmd_ready=1`, state IDLE, `rem=0`.
- Count-N shift latency with `en` held high: the last step happens at edge N after accept. `done` and `cmd_ready` are high in the following cycle.
- A back-to-back command can be accepted in the `done` cycle.
- `en` low in RUN adds one cycle of latency per low cycle. Contents, `rem` and `sout` hold.
- `rst` asserted mid-command: immediate return to reset values. The command is abandoned and no `done` is generated.

## Configuration
- `USR_ROTATE_EN` defined: ROL/ROR are supported.
- `USR_ROTATE_EN` undefined: modes 3 and 4 are treated as illegal (`done` and `err` pulse, data unchanged), and the rotate logic is absent.

## Structure
- Package `usr_pkg`: mode enum `usr_mode_e` (LOAD..ASR), state enum `usr_state_e`.
- Sub-module `usr_step`: purely combinational single-step unit. Inputs: `d`, mode, `sin_lsb`, `sin_msb`. Outputs: next `d` and `sout`. It is instantiated once.

## Test plan
All scenarios use WIDTH=16.
- Reset, then LOAD `0xA5C3` → `data_out=0xA5C3` after the accept edge, `done` for 1 cycle, `err=0`.
- From `0xA5C3`, SHL count 4 with `sin_lsb=1`, `en=1` → `0x5C3F` after 4 steps, `sout=0`, `done` in cycle 5 after accept.
- From `0xA5C3`, ROR count 8 → `0xC3A5`. A second ROR 8 accepted in the `done` cycle → `0xA5C3`. With `USR_ROTATE_EN` undefined, the first command gives `err`, data unchanged.
- From `0x8000`, ASR count 3 → `0xF000`. Then SHR count 3 with `sin_msb=0` → `0x1E00`.
- SHR count 4 with `en` low for 2 cycles mid-run → `done` 2 cycles later than unstalled, same final value, `cmd_valid` during RUN ignored.
- `rst` pulsed during a count-10 SHL → `data_out=0`, `cmd_ready=1` immediately, no `done`. Mode 6 then gives `done` and `err` with data 0 unchanged.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: command modes, FSM states
// and the mode-legality helper (rotate modes depend on USR_ROTATE_EN).
package usr_pkg;

  typedef enum logic [2:0] {
    M_LOAD = 3'd0,
    M_SHL  = 3'd1,
    M_SHR  = 3'd2,
    M_ROL  = 3'd3,
    M_ROR  = 3'd4,
    M_ASR  = 3'd5
  } usr_mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } usr_state_e;

  function automatic logic mode_legal(input logic [2:0] m);
`ifdef USR_ROTATE_EN
    return (m <= 3'd5);
`else
    return (m <= 3'd5) && (m != 3'd3) && (m != 3'd4);
`endif
  endfunction

endpackage

// File: rtl/universal_shift_reg_if.sv
// Command / data bundle for universal_shift_reg; master drives commands,
// slave is the shift register itself.
interface universal_shift_reg_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             en;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] par_in;
  logic             sin_lsb;
  logic             sin_msb;
  logic [WIDTH-1:0] data_out;
  logic             sout;
  logic             done;
  logic             err;

  modport master (
    output en, cmd_valid, cmd_mode, cmd_count, par_in, sin_lsb, sin_msb,
    input  cmd_ready, data_out, sout, done, err
  );

  modport slave (
    input  en, cmd_valid, cmd_mode, cmd_count, par_in, sin_lsb, sin_msb,
    output cmd_ready, data_out, sout, done, err
  );
endinterface

// File: rtl/usr_step.sv
// Single-step combinational shift/rotate unit. Rotate paths exist only when
// USR_ROTATE_EN is defined; otherwise those modes pass data through.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] d,
  input  usr_mode_e        mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  always_comb begin
    q    = d;
    sout = 1'b0;
    case (mode)
      M_SHL: begin
        q    = {d[WIDTH-2:0], sin_lsb};
        sout = d[WIDTH-1];
      end
      M_SHR: begin
        q    = {sin_msb, d[WIDTH-1:1]};
        sout = d[0];
      end
`ifdef USR_ROTATE_EN
      M_ROL: begin
        q    = {d[WIDTH-2:0], d[WIDTH-1]};
        sout = d[WIDTH-1];
      end
      M_ROR: begin
        q    = {d[0], d[WIDTH-1:1]};
        sout = d[0];
      end
`endif
      M_ASR: begin
        q    = {d[WIDTH-1], d[WIDTH-1:1]};
        sout = d[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: LOAD / SHL / SHR / ROL / ROR / ASR, one position
// per enabled cycle, done/err pulses on completion. Macro: USR_ROTATE_EN.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  universal_shift_reg_if.slave bus
);

  usr_state_e       state_q, state_d;
  usr_mode_e        mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] step_q;
  logic             step_sout;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .d       (data_q),
    .mode    (mode_q),
    .sin_lsb (bus.sin_lsb),
    .sin_msb (bus.sin_msb),
    .q       (step_q),
    .sout    (step_sout)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    data_d  = data_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (!mode_legal(bus.cmd_mode)) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (bus.cmd_mode == M_LOAD) begin
            data_d = bus.par_in;
            done_d = 1'b1;
          end else if (bus.cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            // mode is only latched for real multi-step work
            state_d = S_RUN;
            mode_d  = usr_mode_e'(bus.cmd_mode);
            rem_d   = bus.cmd_count;
          end
        end
      end
      S_RUN: begin
        if (bus.en) begin
          data_d = step_q;
          sout_d = step_sout;
          rem_d  = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_LOAD;
      rem_q   <= '0;
      data_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.data_out  = data_q;
  assign bus.sout      = sout_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=16): commands push expected
// results into a queue, a monitor pops and checks on every done pulse.
module tb_universal_shift_reg;

  typedef struct {
    logic [15:0] data;
    logic        sout;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic rs;

  universal_shift_reg_if #(.WIDTH(16)) bus ();

  universal_shift_reg #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event/timeout, expected none (cycle %0d)", nm, cyc);
  endfunction

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (bus.done) begin
        if (sb.size() == 0) fail("unexpected_done");
        else begin
          e = sb.pop_front();
          chk("data_out", 32'(bus.data_out), 32'(e.data));
          chk("sout", 32'(bus.sout), 32'(e.sout));
          chk("err", 32'(bus.err), 32'(e.err));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("ready_in_done", 32'(bus.cmd_ready), 32'd1);
        end
      end else if (bus.err) fail("err_without_done");
    end
  end

  task automatic issue(input logic [2:0] mode, input int cnt, input logic [15:0] par,
                       input logic sl, input logic sm, input logic [15:0] xd,
                       input logic xs, input logic xe, input int lat);
    exp_t e;
    int k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.cmd_ready) begin
      fail("ready_timeout");
      return;
    end
    e.data = xd; e.sout = xs; e.err = xe; e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = mode;
    bus.cmd_count = 5'(cnt);
    bus.par_in    = par;
    bus.sin_lsb   = sl;
    bus.sin_msb   = sm;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      fail("done_timeout");
      sb.delete();
    end
  endtask

  initial begin
    bus.en = 1'b1; bus.cmd_valid = 1'b0; bus.cmd_mode = 3'd0; bus.cmd_count = '0;
    bus.par_in = '0; bus.sin_lsb = 1'b0; bus.sin_msb = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(bus.data_out), 32'h0);
    chk("rst_sout", 32'(bus.sout), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'h1);
    rst = 1'b0;

    issue(3'd0, 0, 16'hA5C3, 0, 0, 16'hA5C3, 0, 0, 0);   wait_idle();
    issue(3'd1, 4, 16'h0000, 1, 0, 16'h5C3F, 0, 0, 4);   wait_idle();
    issue(3'd0, 0, 16'hA5C3, 0, 0, 16'hA5C3, 0, 0, 0);   wait_idle();
`ifdef USR_ROTATE_EN
    issue(3'd4, 8, 16'h0000, 0, 0, 16'hC3A5, 1, 0, 8);
    issue(3'd4, 8, 16'h0000, 0, 0, 16'hA5C3, 1, 0, 8);   wait_idle();
    rs = 1'b1;
`else
    issue(3'd4, 8, 16'h0000, 0, 0, 16'hA5C3, 0, 1, 0);
    issue(3'd4, 8, 16'h0000, 0, 0, 16'hA5C3, 0, 1, 0);   wait_idle();
    rs = 1'b0;
`endif
    issue(3'd0, 0, 16'h8000, 0, 0, 16'h8000, rs, 0, 0);  wait_idle();
    issue(3'd5, 3, 16'h0000, 0, 0, 16'hF000, 0, 0, 3);   wait_idle();
    issue(3'd2, 3, 16'h0000, 0, 0, 16'h1E00, 0, 0, 3);   wait_idle();

    // SHR 4 with two stalled cycles and a LOAD request that must be ignored
    issue(3'd2, 4, 16'h0000, 0, 1, 16'hF1E0, 0, 0, 6);
    bus.cmd_valid = 1'b1; bus.cmd_mode = 3'd0; bus.par_in = 16'hFFFF;
    @(negedge clk); bus.en = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.en = 1'b1; bus.cmd_valid = 1'b0;
    wait_idle();

    issue(3'd1, 1, 16'h0000, 0, 0, 16'hE3C0, 1, 0, 1);   wait_idle();
    issue(3'd1, 0, 16'h0000, 1, 1, 16'hE3C0, 1, 0, 0);   wait_idle();
    issue(3'd1, 17, 16'h0000, 1, 0, 16'hFFFF, 1, 0, 17); wait_idle();
    issue(3'd7, 2, 16'h1234, 0, 0, 16'hFFFF, 1, 1, 0);   wait_idle();

    // reset mid-command abandons it without a done pulse
    issue(3'd1, 10, 16'h0000, 0, 0, 16'h0000, 0, 0, 10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_data", 32'(bus.data_out), 32'h0);
    chk("midrst_ready", 32'(bus.cmd_ready), 32'h1);
    chk("midrst_sout", 32'(bus.sout), 32'h0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    repeat (14) @(negedge clk);
    issue(3'd6, 3, 16'hBEEF, 0, 0, 16'h0000, 0, 1, 0);   wait_idle();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
